// File: rtl/r_channel.sv
// -----------------------------------------------------------------------------
// r_channel
//   OBI R-channel response stage. Sits directly behind the A-channel capture
//   register. Controller completions {err, rdata} are buffered in a small FIFO
//   and offered to the OBI master through an rvalid/rready handshake.
//   Accepted-but-unanswered requests are counted. internal_gnt throttles
//   A-channel capture so that the FIFO can never be oversubscribed.
//
// Parameters
//   DATA_WIDTH       width of ctrl_rdata / obi_rdata
//   DEPTH            response FIFO entries (power of two, >= 2)
//   MAX_OUTSTANDING  accepted-but-unanswered limit (<= DEPTH)
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   a_accept      in   A-channel handshake this cycle
//   ctrl_done     in   controller completes the oldest accepted request
//   ctrl_rdata    in   completion read data ('0 for writes)
//   ctrl_err      in   completion error flag
//   obi_rready    in   master ready to take a response
//   obi_rvalid    out  response valid
//   obi_rdata     out  response data (zero while no response is held)
//   obi_err       out  response error (zero while no response is held)
//   internal_gnt  out  A-channel may accept a new request
//   outstanding   out  current outstanding count
//   overflow_err  out  sticky protocol-violation flag (drop or underflow)
// -----------------------------------------------------------------------------
module r_channel #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   a_accept,
  input  logic                                   ctrl_done,
  input  logic [DATA_WIDTH-1:0]                  ctrl_rdata,
  input  logic                                   ctrl_err,
  input  logic                                   obi_rready,
  output logic                                   obi_rvalid,
  output logic [DATA_WIDTH-1:0]                  obi_rdata,
  output logic                                   obi_err,
  output logic                                   internal_gnt,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   overflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned ENT_W = DATA_WIDTH + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [OUT_W-1:0] OUT_ZERO = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (MAX_OUTSTANDING > DEPTH) begin : g_bad_max_outstanding
    $error("r_channel: MAX_OUTSTANDING (%0d) must be <= DEPTH (%0d)",
           MAX_OUTSTANDING, DEPTH);
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("r_channel: DEPTH (%0d) must be a power of two >= 2", DEPTH);
  end

  // Pointer advance. DEPTH is a power of two, so the natural wrap of a
  // PTR_W-bit add gives the required modulo-DEPTH behaviour.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    ptr_inc = ptr + PTR_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             overflow_q, overflow_d;

  // Handshake / event decode
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             gnt_s;
  logic             inc_s;
  logic             underflow_s;
  logic [ENT_W-1:0] head_s;

  // FIFO status and handshake events, all from registered state plus inputs
  always_comb begin
    empty_s = (count_q == CNT_ZERO);
    full_s  = (count_q == CNT_FULL);
    // obi_rvalid is !empty, so the pop condition is expressed on empty_s.
    pop_s   = ~empty_s & obi_rready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_s  = ctrl_done & (~full_s | pop_s);
    drop_s  = ctrl_done & full_s & ~pop_s;
    gnt_s   = (outstanding_q < OUT_MAX);
    inc_s   = a_accept & gnt_s;
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Outstanding counter next-state and sticky error accumulation
  always_comb begin
    outstanding_d = outstanding_q;
    underflow_s   = 1'b0;
    case ({inc_s, pop_s})
      2'b10: begin
        outstanding_d = outstanding_q + OUT_ONE;
      end
      2'b01: begin
        // A response without a matching request is a protocol violation;
        // hold at zero instead of wrapping.
        if (outstanding_q == OUT_ZERO) begin
          outstanding_d = outstanding_q;
          underflow_s   = 1'b1;
        end else begin
          outstanding_d = outstanding_q - OUT_ONE;
          underflow_s   = 1'b0;
        end
      end
      default: begin
        outstanding_d = outstanding_q;
      end
    endcase
    overflow_d = overflow_q | drop_s | underflow_s;
  end

  // Control-state registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= CNT_ZERO;
      outstanding_q <= OUT_ZERO;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      overflow_q    <= overflow_d;
    end
  end

  // Response storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {ctrl_err, ctrl_rdata};
    end
  end

  // Output decode from registered state only; nothing from ctrl_* reaches obi_*
  // combinationally. While not empty, a push targets wr_ptr != rd_ptr, so the
  // head entry is stable under backpressure.
  always_comb begin
    head_s = mem_q[rd_ptr_q];
    if (empty_s) begin
      obi_rdata = {DATA_WIDTH{1'b0}};
      obi_err   = 1'b0;
    end else begin
      obi_rdata = head_s[DATA_WIDTH-1:0];
      obi_err   = head_s[DATA_WIDTH];
    end
  end

  assign obi_rvalid   = ~empty_s;
  // Decoded from the registered count: a pop does not re-grant in-cycle.
  assign internal_gnt = gnt_s;
  assign outstanding  = outstanding_q;
  assign overflow_err = overflow_q;

endmodule
